// File: rtl/mas_mul_arbiter.sv
// Round-robin share of one 32x32 multiplier among NREQ requesters; MAS_MUL_ARB_FIXED_PRIO_EN selects lowest-index priority.
// Latency: grant cycle t -> rsp_valid from t+LAT+1; one op in flight per requester, no pipeline stall.
// Backpressure: a held result keeps its requester busy (no regrant) until rsp_ready consumes it.
module mas_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [NREQ*64-1:0] rsp_data,
  output logic [31:0]       mul_in1,
  output logic [31:0]       mul_in2,
  input  logic [63:0]       mul_res,
  output logic [NREQ-1:0]   busy
);

  localparam int IDXW = $clog2(NREQ);

  typedef struct packed {
    logic            vld;
    logic [IDXW-1:0] idx;
  } tag_t;

  logic [NREQ-1:0]    elig;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic [NREQ-1:0]    cap;
  logic               gnt_any;
  logic               gnt_vld;
  logic [IDXW-1:0]    gnt_idx;
  tag_t               tag_d;
  tag_t               tag_q [LAT];
  tag_t               tag_out;
  logic [NREQ-1:0]    busy_q;
  logic [NREQ-1:0]    rsp_valid_q;
  logic [NREQ*64-1:0] rsp_data_q;

  assign elig = req_valid & ~busy_q;

`ifdef MAS_MUL_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        gnt_any = 1'b1;
        gnt_idx = IDXW'(i);
      end
    end
  end
`else
  logic [IDXW-1:0] last_q;
  logic [IDXW-1:0] cand;

  // Scan offsets from far to near so the requester just after last_q wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDXW'((int'(last_q) + k) % NREQ);
      if (elig[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= IDXW'(NREQ - 1);
    end else if (gnt_vld) begin
      last_q <= gnt_idx;
    end
  end
`endif

  // Gate with rstn so nothing is granted while reset is held.
  assign gnt_vld = gnt_any & rstn;

  always_comb begin
    grant = '0;
    if (gnt_vld) grant[gnt_idx] = 1'b1;
  end

  assign req_ready = grant;
  assign mul_in1   = gnt_vld ? req_a[32*gnt_idx +: 32] : 32'd0;
  assign mul_in2   = gnt_vld ? req_b[32*gnt_idx +: 32] : 32'd0;

  assign tag_d.vld = gnt_vld;
  assign tag_d.idx = gnt_idx;
  assign tag_out   = tag_q[LAT-1];

  assign done = rsp_valid_q & rsp_ready;

  always_comb begin
    cap = '0;
    if (tag_out.vld) cap[tag_out.idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
      busy_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
      // A capture can never target a requester completing this cycle: it is still busy without a held result.
      busy_q      <= (busy_q | grant) & ~done;
      rsp_valid_q <= (rsp_valid_q & ~done) | cap;
      if (tag_out.vld) rsp_data_q[64*tag_out.idx +: 64] <= mul_res;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mas_mul_arbiter.sv
// Directed and random bench for mas_mul_arbiter with a one-cycle multiplier model and per-requester scoreboard.
module tb_mas_mul_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 1;

  logic               clk = 1'b0;
  logic               rstn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [NREQ*64-1:0] rsp_data;
  logic [31:0]        mul_in1;
  logic [31:0]        mul_in2;
  logic [63:0]        mul_res;
  logic [NREQ-1:0]    busy;

  mas_mul_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .mul_in1   (mul_in1),
    .mul_in2   (mul_in2),
    .mul_res   (mul_res),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared multiplier: one registered stage.
  always @(posedge clk) mul_res <= {32'd0, mul_in1} * {32'd0, mul_in2};

  int              n_cmp = 0;
  int              n_bad = 0;
  logic [63:0]     sb [NREQ][$];
  logic [NREQ-1:0] e_busy;
  logic [NREQ-1:0] e_rv;
  logic [NREQ-1:0] e_gh;
  int              e_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] pick(input logic [NREQ-1:0] el, input int last);
    logic [NREQ-1:0] g = '0;
`ifdef MAS_MUL_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) begin
      if (el[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
`else
    for (int k = 1; k <= NREQ; k++) begin
      int j = (last + k) % NREQ;
      if (el[j]) begin
        g[j] = 1'b1;
        return g;
      end
    end
`endif
    return g;
  endfunction

  task automatic model_reset();
    e_busy = '0;
    e_rv   = '0;
    e_gh   = '0;
    e_last = NREQ - 1;
    for (int i = 0; i < NREQ; i++) sb[i].delete();
  endtask

  // Called at posedge+1 with inputs already driven; checks at the negedge, returns at next posedge+1.
  task automatic cycle();
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] dn;
    logic [31:0]     ea;
    logic [31:0]     eb;
    @(negedge clk);
    eg = pick(req_valid & ~e_busy, e_last);
    ea = 32'd0;
    eb = 32'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (eg[i]) begin
        ea = req_a[32*i +: 32];
        eb = req_b[32*i +: 32];
        sb[i].push_back({32'd0, ea} * {32'd0, eb});
        e_last = i;
      end
    end
    chk("req_ready", 64'(req_ready), 64'(eg));
    chk("mul_in1", 64'(mul_in1), 64'(ea));
    chk("mul_in2", 64'(mul_in2), 64'(eb));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    chk("busy", 64'(busy), 64'(e_busy));
    dn = e_rv & rsp_ready;
    for (int i = 0; i < NREQ; i++) begin
      if (dn[i] && sb[i].size() > 0) chk($sformatf("rsp_data%0d", i), rsp_data[64*i +: 64], sb[i].pop_front());
    end
    e_busy = (e_busy | eg) & ~dn;
    e_rv   = (e_rv & ~dn) | e_gh;
    e_gh   = eg;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rstn      = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mul_in1", 64'(mul_in1), 64'd0);
    chk("rst_mul_in2", 64'(mul_in2), 64'd0);
    for (int i = 0; i < NREQ; i++) chk($sformatf("rst_rsp_data%0d", i), rsp_data[64*i +: 64], 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    logic [63:0] held;
    logic        saw1;
    rstn      = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    req_a     = '0;
    req_b     = '0;
    #1;
    reset_dut();

    // Single op on requester 0.
    req_valid = NREQ'(1);
    req_a[31:0] = 32'd3;
    req_b[31:0] = 32'd5;
    #1;
    chk("single_grant", 64'(req_ready), 64'd1);
    cycle();
    req_valid = '0;
    cycle();
    chk("single_rv", 64'(rsp_valid), 64'd1);
    chk("single_data", rsp_data[63:0], 64'd15);
    cycle();
    chk("single_busy_clear", 64'(busy), 64'd0);
    cycle();

    // Corner operands on requesters 0..2, granted in index order after reset.
    reset_dut();
    req_a[31:0]  = 32'hFFFF_FFFF; req_b[31:0]  = 32'hFFFF_FFFF;
    req_a[63:32] = 32'h8000_0000; req_b[63:32] = 32'd2;
    req_a[95:64] = 32'd0;         req_b[95:64] = 32'hDEAD_BEEF;
    req_valid = NREQ'(7);
    for (int c = 0; c < 3; c++) begin
      cycle();
      req_valid[c] = 1'b0;
    end
    repeat (4) cycle();
    chk("corner_ffff", rsp_data[63:0], 64'hFFFF_FFFE_0000_0001);
    chk("corner_msb", rsp_data[127:64], 64'h0000_0001_0000_0000);
    chk("corner_zero", rsp_data[191:128], 64'd0);

    // All four requesters at once.
    reset_dut();
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = 32'h1000 + 32'(i * 7);
      req_b[32*i +: 32] = 32'h11 * 32'(i + 3);
    end
    req_valid = '1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c < 4) chk($sformatf("all4_grant_c%0d", c), 64'(req_ready), 64'(NREQ'(1) << c));
      chk($sformatf("all4_rv_c%0d", c), 64'(rsp_valid), (c >= 2) ? 64'(NREQ'(1) << (c - 2)) : 64'd0);
      cycle();
      if (c < 4) req_valid[c] = 1'b0;
    end

    // Requester 1 holds its result for 10 cycles while everyone keeps requesting.
    reset_dut();
    rsp_ready = NREQ'(4'b1101);
    req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_a[32*i +: 32] = $urandom;
        req_b[32*i +: 32] = $urandom;
      end
      cycle();
    end
    chk("held_rv1", 64'(rsp_valid[1]), 64'd1);
    held = rsp_data[127:64];
    saw1 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_a[32*i +: 32] = $urandom;
        req_b[32*i +: 32] = $urandom;
      end
      #1;
      saw1 = saw1 | req_ready[1];
      cycle();
    end
    chk("held_no_regrant", 64'(saw1), 64'd0);
    chk("held_data_stable", rsp_data[127:64], held);
    rsp_ready = '1;
    req_valid = '0;
    repeat (4) cycle();

    // Reset while requesters 0 and 2 are in flight.
    reset_dut();
    req_valid = NREQ'(4'b0101);
    cycle();
    req_valid = NREQ'(4'b0100);
    cycle();
    reset_dut();
    repeat (6) cycle();

    // Random soak.
    for (int c = 0; c < 10000; c++) begin
      req_valid = NREQ'($urandom);
      rsp_ready = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_a[32*i +: 32] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        req_b[32*i +: 32] = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      end
      cycle();
    end
    req_valid = '0;
    rsp_ready = '1;
    repeat (6) cycle();
    for (int i = 0; i < NREQ; i++) chk($sformatf("drain%0d", i), 64'(sb[i].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
